// File: rtl/mult_div_pkg.sv
// Shared constants and FSM state encoding for the signed multiply/divide unit.
package mult_div_pkg;

  // Operand width and number of iteration steps per operation.
  localparam int N     = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  // Booth accumulator layout: {HI[N-1:0], LO[N-1:0], q-1}.
  localparam int ACC_W = 2 * N + 1;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration on the {HI, LO, q-1} accumulator.
// The low pair {LO[0], q-1} selects add, subtract or nothing on HI against
// the multiplicand, then the whole accumulator shifts right arithmetically.
// HI is widened by one bit before the add so that a -2^31 multiplicand
// cannot overflow the partial product before the shift.
module booth_step
  import mult_div_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [N-1:0]     mcand_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [N:0] hi_ext;
  logic [N:0] m_ext;
  logic [N:0] sum;

  // Add/subtract the multiplicand on HI, then arithmetic-shift the accumulator.
  always_comb begin
    hi_ext = {acc_i[ACC_W-1], acc_i[ACC_W-1 -: N]};
    m_ext  = {mcand_i[N-1], mcand_i};
    case (acc_i[1:0])
      2'b01:   sum = hi_ext + m_ext;
      2'b10:   sum = hi_ext - m_ext;
      default: sum = hi_ext;
    endcase
    // sum keeps the sign bit, old LO drops its bit 0 into the new q-1.
    acc_o = {sum, acc_i[N:1]};
  end

endmodule

// File: rtl/mult_div.sv
// Iterative signed 32-bit multiply (radix-2 Booth) and divide (restoring).
//
// Handshake: a start is a level on MultCtrl or DivCtrl seen at a rising edge
// while the unit is IDLE (multiply wins if both are high); A and B are
// captured on that same edge. Starts seen while busy are dropped, never
// queued. done is a one-cycle pulse marking new HI_out/LO_out; the unit is
// IDLE again in that cycle and accepts a new start. A divide with B==0 does
// not start; it raises DivZero for one cycle and leaves HI_out/LO_out alone.
//
// Both operations share the working HI/LO registers and the step counter.
// HI_out/LO_out are separate registers, so the visible result only changes
// on the FIN->IDLE transition.
module mult_div #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         MultCtrl,
  input  logic         DivCtrl,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] HI_out,
  output logic [N-1:0] LO_out,
  output logic         busy,
  output logic         done,
  output logic         DivZero,
  output logic [1:0]   dbg_state_o
);

  import mult_div_pkg::*;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       hi_q, hi_d;        // working HI: Booth high word / partial remainder
  logic [N-1:0]       lo_q, lo_d;        // working LO: multiplier / dividend -> quotient
  logic               qm1_q, qm1_d;      // Booth q-1 bit
  logic [N-1:0]       opb_q, opb_d;      // multiplicand (MULT) or divisor magnitude (DIV)
  logic               op_div_q, op_div_d;
  logic               qneg_q, qneg_d;    // quotient needs negating
  logic               rneg_q, rneg_d;    // remainder takes the dividend's negative sign

  logic [N-1:0]       hi_out_q, lo_out_q;
  logic               done_q, divz_q;

  logic               start_mult;
  logic               start_div;
  logic               div_zero;
  logic               last_step;
  logic [N-1:0]       a_mag, b_mag;
  logic [N:0]         div_shift, div_diff;
  logic               div_ge;
  logic [ACC_W-1:0]   booth_in, booth_out;
  logic [N-1:0]       hi_res, lo_res;

  // Booth step datapath on the shared working registers.
  assign booth_in = {hi_q, lo_q, qm1_q};

  booth_step u_booth_step (
    .acc_i   (booth_in),
    .mcand_i (opb_q),
    .acc_o   (booth_out)
  );

  // Start decode, operand magnitudes, restoring-divide step and sign fix-up.
  always_comb begin
    start_mult = (state_q == IDLE) && MultCtrl;
    start_div  = (state_q == IDLE) && !MultCtrl && DivCtrl && (B != '0);
    div_zero   = (state_q == IDLE) && !MultCtrl && DivCtrl && (B == '0);
    last_step  = (cnt_q == CNT_W'(ITER - 1));

    // -2^31 maps to 0x80000000, which is its correct unsigned magnitude.
    a_mag = A[N-1] ? (~A + 1'b1) : A;
    b_mag = B[N-1] ? (~B + 1'b1) : B;

    // Partial remainder stays below the divisor, so one extra bit is enough
    // and the borrow bit of the trial subtraction is the compare result.
    div_shift = {hi_q, lo_q[N-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = !div_diff[N];

    hi_res = (op_div_q && rneg_q) ? (~hi_q + 1'b1) : hi_q;
    lo_res = (op_div_q && qneg_q) ? (~lo_q + 1'b1) : lo_q;
  end

  // Next-state and working-register update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    qm1_d    = qm1_q;
    opb_d    = opb_q;
    op_div_d = op_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    case (state_q)
      IDLE: begin
        if (start_mult) begin
          state_d  = MULT;
          cnt_d    = '0;
          hi_d     = '0;
          lo_d     = B;
          qm1_d    = 1'b0;
          opb_d    = A;
          op_div_d = 1'b0;
          qneg_d   = 1'b0;
          rneg_d   = 1'b0;
        end else if (start_div) begin
          state_d  = DIV;
          cnt_d    = '0;
          hi_d     = '0;
          lo_d     = a_mag;
          qm1_d    = 1'b0;
          opb_d    = b_mag;
          op_div_d = 1'b1;
          qneg_d   = A[N-1] ^ B[N-1];
          rneg_d   = A[N-1];
        end
      end
      MULT: begin
        {hi_d, lo_d, qm1_d} = booth_out;
        cnt_d = cnt_q + 1'b1;
        if (last_step) state_d = FIN;
      end
      DIV: begin
        hi_d  = div_ge ? div_diff[N-1:0] : div_shift[N-1:0];
        lo_d  = {lo_q[N-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (last_step) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and working registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      opb_q    <= '0;
      op_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      qm1_q    <= qm1_d;
      opb_q    <= opb_d;
      op_div_q <= op_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  // Visible result registers and one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_out_q <= '0;
      lo_out_q <= '0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      if (state_q == FIN) begin
        hi_out_q <= hi_res;
        lo_out_q <= lo_res;
      end
      done_q <= (state_q == FIN);
      divz_q <= div_zero;
    end
  end

  assign HI_out      = hi_out_q;
  assign LO_out      = lo_out_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign DivZero     = divz_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 Parameter: N, 32, operand width; only N=32 is supported.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 MultCtrl  in  1  start signed multiply; sampled only in IDLE.
REQ-005 DivCtrl  in  1  start signed divide; sampled only in IDLE.
REQ-006 A  in  32  multiplicand / dividend; captured on the start-sampling edge.
REQ-007 B  in  32  multiplier / divisor; captured on the start-sampling edge.
REQ-008 HI_out  out  32  product high word / remainder; feeds the HI register path of DataSrc.
REQ-009 LO_out  out  32  product low word / quotient; feeds the LO register path of DataSrc.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 done  out  1  registered one-cycle pulse: new HI_out/LO_out valid.
REQ-012 DivZero  out  1  registered one-cycle pulse: divide started with B==0.

Function
REQ-013 The FSM SHALL have states IDLE, MULT, DIV and FIN, with a 5-bit iteration counter.
REQ-014 In IDLE: MultCtrl=1 -> MULT; else DivCtrl=1 and B!=0 -> DIV; else DivCtrl=1 and B==0 -> stay IDLE, DivZero=1 next cycle; A and B are latched on the same edge.
REQ-015 If MultCtrl and DivCtrl are both high in IDLE, multiply SHALL win and divide SHALL be ignored.
REQ-016 MultCtrl/DivCtrl outside IDLE SHALL be ignored; they are not queued.
REQ-017 MULT: radix-2 Booth, one step per cycle, 32 steps over a 65-bit {HI,LO,q-1} accumulator.
REQ-018 DIV: restoring division on operand magnitudes, one quotient bit per cycle, 32 steps.
REQ-019 After the 32nd step the FSM SHALL enter FIN and apply sign fix-up (quotient negated if signs differ; remainder takes dividend sign), then return to IDLE.
REQ-020 Timing: with E0 the start-sampling edge, steps occur at E1..E32, FIN is entered at E32, and HI_out/LO_out update with done=1 at E33, giving 33-cycle latency.
REQ-021 done SHALL be high exactly one cycle; since the state is IDLE then, a start in the done cycle is accepted.
REQ-022 HI_out/LO_out SHALL change only at FIN->IDLE and hold otherwise, including across DivZero.
REQ-023 Multiply results: HI:LO = signed 64-bit A*B.
REQ-024 Divide results: LO = quotient truncated toward zero, HI = A - LO*B.
REQ-025 Overflow case 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0 (32-bit wrap), with no flag.
REQ-026 busy SHALL be high from E0 through the FIN cycle and low in the done cycle.

Reset
REQ-027 reset SHALL force state IDLE, counter 0, HI_out=0, LO_out=0, busy=0, done=0, DivZero=0, immediately and independent of clk.
REQ-028 Reset mid-operation SHALL abort it with no partial write; the first start after release SHALL behave per REQ-014.

Structure
REQ-029 Package mult_div_pkg SHALL hold the state enum, N=32 and ITER=32.
REQ-030 Sub-module booth_step SHALL be the one natural sub-module: combinational add/sub/shift of the 65-bit accumulator; the divider step stays inline.
REQ-031 Multiply and divide SHALL share the iteration counter and the HI/LO registers.

Verification
REQ-032 MultCtrl, A=7, B=0xFFFFFFFD -> done at E33, HI_out=0xFFFFFFFF, LO_out=0xFFFFFFEB.
REQ-033 MultCtrl, A=B=0x80000000 -> HI_out=0x40000000, LO_out=0x00000000.
REQ-034 DivCtrl, A=0xFFFFFFF9 (-7), B=2 -> LO_out=0xFFFFFFFD, HI_out=0xFFFFFFFF, DivZero=0.
REQ-035 DivCtrl, A=100, B=0 -> DivZero one cycle after E0, busy never high, done=0, HI_out/LO_out unchanged.
REQ-036 DivCtrl, A=0x80000000, B=0xFFFFFFFF -> LO_out=0x80000000, HI_out=0.
REQ-037 Reset asserted at E10 of a multiply -> all outputs 0 at once; MultCtrl together with DivCtrl (A=3, B=5) after release -> multiply runs, LO_out=15, done at E33.
